// File: rtl/hdb3_rx_link_ctrl.sv
// Receive-side HDB3 link controller: code-rule checking, LOS/ACQ/LOCKED tracking,
// decoder reset and data-valid alignment. Define HDB3_ERR_CNT_EN to build o_err_cnt.
module hdb3_rx_link_ctrl #(
    parameter int LOS_ZEROS  = 16,
    parameter int LOCK_SYMS  = 64,
    parameter int WIN_LEN    = 256,
    parameter int ERR_THRESH = 4,
    parameter int DEC_LAT    = 6
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_hdb3_code,
    input  logic        i_err_clr,
    output logic        o_dec_rst_n,
    output logic        o_data_valid,
    output logic [1:0]  o_link_state,
    output logic        o_los,
    output logic        o_code_err,
    output logic [15:0] o_err_cnt
);
    localparam int ZW = $clog2(LOS_ZEROS + 1);
    localparam int LW = $clog2(LOCK_SYMS + 1);
    localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int EW = $clog2(ERR_THRESH + 1);

    typedef enum logic [1:0] {LOS = 2'b00, ACQ = 2'b01, LOCKED = 2'b10} state_t;
    // Polarity history reuses the symbol encoding, with 00 meaning "no history".
    localparam logic [1:0] POL_NONE = 2'b00;

    state_t             st, st_nx;
    logic [1:0]         s1, last_pol, last_viol;
    logic [ZW-1:0]      zero_run, zero_run_nx;
    logic [LW-1:0]      lock_cnt, lock_inc;
    logic [WW-1:0]      win_cnt;
    logic [EW-1:0]      win_err, win_err_nx;
    logic [DEC_LAT-1:0] vld_pipe;
    logic               is_zero, is_pulse, los_hit, viol, code_err, win_wrap;

    always_comb begin
        is_zero     = (s1 == 2'b00) || (s1 == 2'b11);
        is_pulse    = !is_zero;
        zero_run_nx = '0;
        if (is_zero)
            zero_run_nx = (zero_run == ZW'(LOS_ZEROS)) ? zero_run : zero_run + ZW'(1);
        los_hit = is_zero && (zero_run_nx == ZW'(LOS_ZEROS));
        viol    = is_pulse && (last_pol != POL_NONE) && (s1 == last_pol);
        // LOS entry outranks every code error on the same symbol
        code_err = (st != LOS) && !los_hit &&
                   ((s1 == 2'b11) || (is_zero && zero_run_nx == ZW'(4)) ||
                    (viol && (((last_viol != POL_NONE) && (s1 == last_viol)) ||
                              (zero_run < ZW'(2)))));
        lock_inc   = lock_cnt + LW'(1);
        win_wrap   = (win_cnt == WW'(WIN_LEN - 1));
        win_err_nx = win_err + EW'(code_err);
        st_nx = st;
        if (los_hit)
            st_nx = LOS;
        else begin
            case (st)
                LOS:     if (is_pulse) st_nx = ACQ;
                ACQ:     if (!code_err && lock_inc == LW'(LOCK_SYMS)) st_nx = LOCKED;
                LOCKED:  if (win_err_nx == EW'(ERR_THRESH)) st_nx = ACQ;
                default: st_nx = LOS;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st          <= LOS;
            s1          <= 2'b00;
            zero_run    <= '0;
            last_pol    <= POL_NONE;
            last_viol   <= POL_NONE;
            lock_cnt    <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            vld_pipe    <= '0;
            o_code_err  <= 1'b0;
            o_los       <= 1'b1;
            o_dec_rst_n <= 1'b0;
        end else begin
            s1          <= i_hdb3_code;
            st          <= st_nx;
            zero_run    <= zero_run_nx;
            o_code_err  <= code_err;
            o_los       <= (st_nx == LOS);
            o_dec_rst_n <= (st_nx != LOS);
            // The pulse that leaves LOS is not remembered; checking restarts from scratch.
            if (st == LOS || st_nx == LOS) begin
                last_pol  <= POL_NONE;
                last_viol <= POL_NONE;
            end else if (is_pulse) begin
                last_pol <= s1;
                if (viol) last_viol <= s1;
            end
            if (st != ACQ || code_err) lock_cnt <= '0;
            else                       lock_cnt <= lock_inc;
            if (st != LOCKED || st_nx != LOCKED) begin
                win_cnt <= '0;
                win_err <= '0;
            end else begin
                win_cnt <= win_wrap ? '0 : win_cnt + WW'(1);
                win_err <= win_wrap ? '0 : win_err_nx;
            end
            // Tags follow the symbol through the decoder latency; LOS flushes them at once.
            if (st_nx == LOS) vld_pipe <= '0;
            else              vld_pipe <= {vld_pipe[DEC_LAT-2:0], st_nx == LOCKED};
        end
    end

    assign o_link_state = st;
    assign o_data_valid = vld_pipe[DEC_LAT-1];

`ifdef HDB3_ERR_CNT_EN
    logic [15:0] err_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                         err_cnt <= '0;
        else if (i_err_clr)                   err_cnt <= {15'd0, code_err};
        else if (code_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
    assign o_err_cnt = err_cnt;
`else
    logic unused_err_clr;
    assign unused_err_clr = i_err_clr;
    assign o_err_cnt      = 16'h0;
`endif
endmodule

// File: tb/tb_hdb3_rx_link_ctrl.sv
// Bench for hdb3_rx_link_ctrl: directed phases plus random symbols against a rule-level model.
module tb_hdb3_rx_link_ctrl;
    localparam int LOS_ZEROS  = 16;
    localparam int LOCK_SYMS  = 64;
    localparam int WIN_LEN    = 256;
    localparam int ERR_THRESH = 4;
    localparam int DEC_LAT    = 6;

    logic        i_clk, i_rst_n, i_err_clr;
    logic [1:0]  i_hdb3_code;
    logic        o_dec_rst_n, o_data_valid, o_los, o_code_err;
    logic [1:0]  o_link_state;
    logic [15:0] o_err_cnt;

    int errors = 0;
    int checks = 0;

    hdb3_rx_link_ctrl #(
        .LOS_ZEROS(LOS_ZEROS), .LOCK_SYMS(LOCK_SYMS), .WIN_LEN(WIN_LEN),
        .ERR_THRESH(ERR_THRESH), .DEC_LAT(DEC_LAT)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_hdb3_code(i_hdb3_code), .i_err_clr(i_err_clr),
        .o_dec_rst_n(o_dec_rst_n), .o_data_valid(o_data_valid), .o_link_state(o_link_state),
        .o_los(o_los), .o_code_err(o_code_err), .o_err_cnt(o_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: 0=LOS 1=ACQ 2=LOCKED, polarity +1/-1 with 0 as "none".
    int         m_st, m_zrun, m_lp, m_lv, m_lock, m_wpos, m_werr, m_cnt, enc_lp, enc_np;
    bit         m_err;
    logic [1:0] m_s1;
    int         m_aft[$];

    task automatic m_reset();
        m_st = 0; m_zrun = 0; m_lp = 0; m_lv = 0; m_lock = 0;
        m_wpos = 0; m_werr = 0; m_cnt = 0; m_err = 0; m_s1 = 2'b00;
        m_aft.delete();
    endtask

    task automatic model_step(input logic [1:0] sym, input bit clr);
        bit zero;
        int pol, zbefore;
        zero    = (sym == 2'b00) || (sym == 2'b11);
        pol     = (sym == 2'b01) ? 1 : (sym == 2'b10) ? -1 : 0;
        zbefore = m_zrun;
        m_err   = 0;
        m_zrun  = zero ? ((m_zrun >= LOS_ZEROS) ? LOS_ZEROS : m_zrun + 1) : 0;
        if (zero && m_zrun == LOS_ZEROS) begin
            m_st = 0; m_lp = 0; m_lv = 0;
        end else if (m_st == 0) begin
            if (!zero) begin m_st = 1; m_lock = 0; end
        end else begin
            m_err = (sym == 2'b11) || (zero && m_zrun == 4);
            if (pol != 0) begin
                if (m_lp == pol) begin
                    if (m_lv == pol || zbefore < 2) m_err = 1;
                    m_lv = pol;
                end
                m_lp = pol;
            end
            if (m_st == 1) begin
                m_lock = m_err ? 0 : m_lock + 1;
                if (m_lock == LOCK_SYMS) begin m_st = 2; m_wpos = 0; m_werr = 0; end
            end else begin
                m_werr += int'(m_err);
                if (m_werr == ERR_THRESH) begin
                    m_st = 1; m_lock = 0;
                end else begin
                    m_wpos++;
                    if (m_wpos == WIN_LEN) begin m_wpos = 0; m_werr = 0; end
                end
            end
        end
        if (clr) m_cnt = int'(m_err);
        else if (m_err && m_cnt < 65535) m_cnt++;
        m_aft.push_back(m_st);
        if (m_aft.size() > DEC_LAT) void'(m_aft.pop_front());
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit v;
        int n;
        logic [15:0] exp_cnt;
        n = m_aft.size();
        v = 0;
        // Valid only if the symbol DEC_LAT back was locked and no LOS occurred since.
        if (n >= DEC_LAT) begin
            v = (m_aft[n-DEC_LAT] == 2);
            for (int j = n - DEC_LAT; j < n; j++) if (m_aft[j] == 0) v = 0;
        end
`ifdef HDB3_ERR_CNT_EN
        exp_cnt = 16'(m_cnt);
`else
        exp_cnt = 16'h0;
`endif
        chk("link_state", 16'(o_link_state), 16'(m_st));
        chk("los",        16'(o_los),        16'(m_st == 0));
        chk("dec_rst_n",  16'(o_dec_rst_n),  16'(m_st != 0));
        chk("code_err",   16'(o_code_err),   16'(m_err));
        chk("data_valid", 16'(o_data_valid), 16'(v));
        chk("err_cnt",    o_err_cnt,         exp_cnt);
    endtask

    task automatic chk_reset();
        chk("rst_dec_rst_n",  16'(o_dec_rst_n),  16'd0);
        chk("rst_data_valid", 16'(o_data_valid), 16'd0);
        chk("rst_link_state", 16'(o_link_state), 16'd0);
        chk("rst_los",        16'(o_los),        16'd1);
        chk("rst_code_err",   16'(o_code_err),   16'd0);
        chk("rst_err_cnt",    o_err_cnt,         16'd0);
    endtask

    // Symbol driven now is sampled at the next edge; that edge classifies the previous one.
    task automatic step(input logic [1:0] sym, input bit clr);
        i_hdb3_code = sym;
        i_err_clr   = clr;
        @(posedge i_clk);
        model_step(m_s1, clr);
        m_s1 = sym;
        if (sym == 2'b01) enc_lp = 1;
        else if (sym == 2'b10) enc_lp = -1;
        @(negedge i_clk);
        check_all();
    endtask

    function automatic logic [1:0] psym(input int p);
        return (p > 0) ? 2'b01 : 2'b10;
    endfunction

    // HDB3 encoder over random data: AMI marks, 000V / B00V for each run of four zeros.
    task automatic send_hdb3(input int nbits);
        int pend;
        pend = 0;
        for (int i = 0; i < nbits; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                repeat (pend) step(2'b00, 1'b0);
                pend = 0;
                step(psym(-enc_lp), 1'b0);
                enc_np++;
            end else begin
                pend++;
                if (pend == 4) begin
                    pend = 0;
                    if (enc_np % 2 == 1) begin
                        repeat (3) step(2'b00, 1'b0);
                        step(psym(enc_lp), 1'b0);
                    end else begin
                        step(psym(-enc_lp), 1'b0);
                        repeat (2) step(2'b00, 1'b0);
                        step(psym(enc_lp), 1'b0);
                    end
                    enc_np = 0;
                end
            end
        end
        repeat (pend) step(2'b00, 1'b0);
    endtask

    initial begin
        int r;
        i_rst_n = 1'b0; i_hdb3_code = 2'b00; i_err_clr = 1'b0;
        enc_lp = 1; enc_np = 0;
        m_reset();
        #7;
        chk_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;

        repeat (20) step(2'b00, 1'b0);
        chk("idle_los", 16'(o_los), 16'd1);

        send_hdb3(120);
        chk("locked_after_stream", 16'(o_link_state), 16'd2);
        chk("no_err_after_stream", o_err_cnt, 16'd0);

        step(2'b11, 1'b0);
        step(psym(-enc_lp), 1'b0);
        chk("illegal_pulse", 16'(o_code_err), 16'd1);
        chk("illegal_keeps_lock", 16'(o_link_state), 16'd2);
`ifdef HDB3_ERR_CNT_EN
        chk("illegal_cnt", o_err_cnt, 16'd1);
`else
        chk("illegal_cnt", o_err_cnt, 16'd0);
`endif
        send_hdb3(10);

        // Repeated same-polarity violations with two zeros each
        repeat (5) begin
            step(2'b00, 1'b0); step(2'b00, 1'b0); step(psym(enc_lp), 1'b0);
        end
        send_hdb3(20);
        chk("viol_drop_acq", 16'(o_link_state), 16'd1);
        chk("viol_drained",  16'(o_data_valid), 16'd0);

        send_hdb3(120);
        chk("relock", 16'(o_link_state), 16'd2);
        repeat (16) step(2'b00, 1'b0);
        chk("zeros_los",       16'(o_link_state), 16'd0);
        chk("zeros_dec_rst_n", 16'(o_dec_rst_n),  16'd0);
        chk("zeros_valid",     16'(o_data_valid), 16'd0);

        step(2'b01, 1'b0);
`ifdef HDB3_ERR_CNT_EN
        repeat (33000) begin step(2'b11, 1'b0); step(2'b01, 1'b0); end
        chk("cnt_saturated", o_err_cnt, 16'hFFFF);
        step(2'b11, 1'b0);
        step(2'b01, 1'b1);
        chk("clr_with_err", o_err_cnt, 16'd1);
`else
        repeat (20) begin step(2'b11, 1'b0); step(2'b01, 1'b0); end
        chk("cnt_tied_off", o_err_cnt, 16'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(99, 0);
            step((r < 40) ? 2'b01 : (r < 80) ? 2'b10 : (r < 97) ? 2'b00 : 2'b11,
                 ($urandom_range(31, 0) == 0));
        end
        send_hdb3(120);

        #2 i_rst_n = 1'b0;
        #1 chk_reset();
        m_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        send_hdb3(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hdb3_rx_link_ctrl.md
# hdb3_rx_link_ctrl

Receive-side link controller for the HDB3 decoder. It watches the same 2-bit line-code stream that feeds the decoder and classifies every symbol for HDB3 code-rule errors. A LOS/ACQ/LOCKED state machine drives the decoder's reset, so the decoder is held flushed while the line is dead. It also produces a data-valid strobe aligned to the decoder output, plus loss-of-signal, error-pulse and error-count status.

## Interface
Parameters:
- LOS_ZEROS, 16: consecutive zero symbols that declare loss of signal.
- LOCK_SYMS, 64: consecutive error-free symbols in ACQ required to lock.
- WIN_LEN, 256: symbol window length for error monitoring in LOCKED.
- ERR_THRESH, 4: errors within one window that drop LOCKED to ACQ.
- DEC_LAT, 6: clock edges from decoder input sampling to the symbol appearing on the decoder's o_data.

Ports:
- i_clk  in  1  single clock; one symbol per cycle.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_hdb3_code  in  2  line symbol: 00 = 0, 01 = +1, 10 = -1, 11 = illegal.
- i_err_clr  in  1  synchronous clear of o_err_cnt.
- o_dec_rst_n  out  1  registered active-low reset to the decoder.
- o_data_valid  out  1  high while the decoder's o_data carries a locked symbol.
- o_link_state  out  2  00 = LOS, 01 = ACQ, 10 = LOCKED.
- o_los  out  1  high in LOS.
- o_code_err  out  1  one-cycle pulse per erroneous symbol.
- o_err_cnt  out  16  saturating error count.

## Operation
- **Pipeline:**
  - Edge E0 captures i_hdb3_code into s1.
  - Edge E1 classifies s1 and updates all tracking registers and outputs.
- **Tracking registers:**
  - Zero-run counter: saturates at LOS_ZEROS; 11 counts as a zero.
  - Last pulse polarity and last violation polarity: each has a "none" state.
  - Zeros-before-pulse count.
- **Violation:** a pulse with the same polarity as the last pulse.
- **Code errors** (detected only outside LOS):
  - Illegal symbol 11.
  - Zero run reaching 4; flagged once per run.
  - A violation whose polarity equals the last violation polarity.
  - A violation preceded by fewer than 2 zeros.
  - Polarity checks with "none" history are skipped.
- **State machine:**
  - Reset state is LOS.
  - In LOS, the zero-run counter runs but no errors are flagged and polarity history is held at "none".
  - LOS→ACQ: on any 01 or 10 symbol; the lock counter starts at 0.
  - ACQ: each error-free symbol increments the lock counter; an error clears it. Reaching LOCK_SYMS → LOCKED.
  - LOCKED: the window counter and window error counter reset on entry. The window counter wraps every WIN_LEN symbols, clearing the error count. Error count reaching ERR_THRESH → ACQ.
  - Any state: zero run reaching LOS_ZEROS → LOS, and polarity history clears. This has priority over every other transition and error.
- **o_dec_rst_n:** registered as (next state ≠ LOS), so the decoder is held in reset throughout LOS.
- **o_data_valid:** a tag pipeline shifts in (state after E1 == LOCKED). The pipeline is cleared while in LOS. The output is delayed so it asserts DEC_LAT edges after the tagged symbol was sampled.
- **o_err_cnt:**
  - Increments on o_code_err and saturates at 16'hFFFF.
  - i_err_clr together with an error in the same cycle gives 1.

## Timing
- Reset values: o_dec_rst_n = 0, o_data_valid = 0, o_link_state = 00, o_los = 1, o_code_err = 0, o_err_cnt = 0. All internal counters and the tag pipeline = 0; polarity history = none.
- A symbol sampled at E0 gives o_code_err, state and o_los updates after E1, i.e. 2-cycle latency.
- The pulse that causes LOS→ACQ releases o_dec_rst_n at E1. That pulse itself is lost to the decoder.
- An ACQ→LOCKED transition at E1 gives first o_data_valid = 1 after E0 + DEC_LAT.
- A LOCKED→ACQ transition lets already-tagged symbols drain from the pipeline. A transition to LOS drops o_data_valid after the same edge.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronously).

## Configuration
- HDB3_ERR_CNT_EN
  - Defined: o_err_cnt and i_err_clr are functional as above.
  - Undefined: the counter logic is removed, o_err_cnt is tied to 16'h0 and i_err_clr is ignored. o_code_err and the state machine are unchanged.

## Test plan
- Reset, then 20 × 00 symbols: o_los = 1, o_dec_rst_n = 0, o_link_state = 00, o_code_err never asserts.
- From LOS, send a valid HDB3 stream (+1, -1, alternating, with 000V/B00V substitutions): ACQ 2 cycles after the first pulse, LOCKED after 64 symbols, o_data_valid rising DEC_LAT edges after the locking symbol, zero errors.
- While LOCKED, inject one 11 symbol: o_code_err pulses 2 cycles later, o_err_cnt = 1, state stays LOCKED.
- While LOCKED, inject 4 same-polarity violations within 256 symbols: o_link_state → 01 after the 4th; o_data_valid deasserts after the pipeline drains.
- While LOCKED, send 16 × 00: one excess-zero error at the 4th zero, LOS after the 16th, o_dec_rst_n = 0, o_data_valid = 0 the same cycle.
- Force o_err_cnt to 16'hFFFF with further errors: it holds; i_err_clr together with an error yields 1. In a build without the macro, o_err_cnt stays 0.
